guess_entry: RTL and testbench

//  Player-input side of the LED display path: debounces five push-buttons, edits a 4-slot colour guess, and drives

---
 rtl/mastermind_pkg.sv | 33 +++
 rtl/btn_debounce.sv | 52 +++++
 rtl/guess_entry.sv | 161 ++++++++++++++++
 tb/tb_guess_entry.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mastermind_pkg.sv
// Shared types and constants for the guess-entry datapath.
package mastermind_pkg;

    localparam int unsigned SLOT_W    = 3;
    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned GUESS_W   = SLOT_W * NUM_SLOTS;
    localparam int unsigned CNT_W     = 4;

    localparam logic [SLOT_W-1:0] COLOR_OFF = 3'b000;

    typedef enum logic [1:0] {
        EDIT    = 2'd0,
        SUBMIT  = 2'd1,
        HISTORY = 2'd2,
        DONE    = 2'd3
    } state_e;

    // One-cycle press pulses from the debounced buttons.
    typedef struct packed {
        logic submit;
        logic mode;
        logic color;
        logic left;
        logic right;
    } btn_t;

    // Next colour in the cycle 1..num_colors; empty (000) steps to 1.
    function automatic logic [SLOT_W-1:0] next_color(input logic [SLOT_W-1:0] c,
                                                     input int unsigned num_colors);
        return (c == SLOT_W'(num_colors)) ? SLOT_W'(1) : c + SLOT_W'(1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchroniser -> stability counter -> one-cycle rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // Count consecutive samples that disagree with the accepted level; flip after enough.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = stable_d & ~stable_q;
    end

    // State registers; reset drops any press in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/guess_entry.sv
// Player input path: debounced buttons edit a 4-slot guess, submit it, and browse history.
// Optional build macro: GUESS_FULL_CHECK_EN (reject submits while any slot is empty).
import mastermind_pkg::*;

module guess_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned NUM_COLORS      = 6,
    parameter int unsigned MAX_GUESSES     = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_color,
    input  logic               btn_submit,
    input  logic               btn_mode,
    output logic [SLOT_W-1:0]  guess_rgb0,
    output logic [SLOT_W-1:0]  guess_rgb1,
    output logic [SLOT_W-1:0]  guess_rgb2,
    output logic [SLOT_W-1:0]  guess_rgb3,
    output logic               blink_enable,
    output logic [1:0]         blink_led,
    output logic               guess_valid,
    output logic [GUESS_W-1:0] guess_word,
    output logic [CNT_W-1:0]   guess_count,
    output logic [CNT_W-1:0]   history_idx,
    output logic               game_over
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_GUESSES);

    btn_t btn;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left   (.clk(clk), .rst(rst), .btn_in(btn_left),   .press(btn.left));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right  (.clk(clk), .rst(rst), .btn_in(btn_right),  .press(btn.right));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_color  (.clk(clk), .rst(rst), .btn_in(btn_color),  .press(btn.color));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_submit (.clk(clk), .rst(rst), .btn_in(btn_submit), .press(btn.submit));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode   (.clk(clk), .rst(rst), .btn_in(btn_mode),   .press(btn.mode));

    state_e                            state_q, state_d;
    logic [NUM_SLOTS-1:0][SLOT_W-1:0]  slot_q, slot_d;
    logic [1:0]                        cursor_q, cursor_d;
    logic                              valid_q, valid_d;
    logic [GUESS_W-1:0]                word_q, word_d;
    logic [CNT_W-1:0]                  count_q, count_d;
    logic [CNT_W-1:0]                  hidx_q, hidx_d;
    logic                              blink_en_q, blink_en_d;
    logic                              over_q, over_d;

    logic             full_ok;
    logic             left_only, right_only;
    logic [CNT_W-1:0] hist_last;

    // Whether the current guess may be submitted.
    always_comb begin
`ifdef GUESS_FULL_CHECK_EN
        full_ok = 1'b1;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (slot_q[i] == COLOR_OFF) full_ok = 1'b0;
        end
`else
        full_ok = 1'b1;
`endif
    end

    assign left_only  = btn.left & ~btn.right;
    assign right_only = btn.right & ~btn.left;
    assign hist_last  = (count_q == '0) ? '0 : count_q - CNT_W'(1);

    // Next-state and next-output logic; priority submit > mode > color > left/right.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        cursor_d = cursor_q;
        valid_d  = 1'b0;
        word_d   = word_q;
        count_d  = count_q;
        hidx_d   = hidx_q;
        unique case (state_q)
            EDIT: begin
                if (btn.submit) begin
                    if (full_ok) begin
                        state_d = SUBMIT;
                        valid_d = 1'b1;
                        word_d  = slot_q;
                        count_d = (count_q == MAX_CNT) ? count_q : count_q + CNT_W'(1);
                    end
                end else if (btn.mode) begin
                    state_d = HISTORY;
                    hidx_d  = hist_last;
                end else if (btn.color) begin
                    slot_d[cursor_q] = next_color(slot_q[cursor_q], NUM_COLORS);
                end else if (left_only) begin
                    cursor_d = cursor_q - 2'd1;
                end else if (right_only) begin
                    cursor_d = cursor_q + 2'd1;
                end
            end
            SUBMIT: begin
                slot_d   = '0;
                cursor_d = 2'd0;
                state_d  = (count_q == MAX_CNT) ? DONE : EDIT;
            end
            HISTORY: begin
                if (btn.mode) begin
                    state_d = (count_q == MAX_CNT) ? DONE : EDIT;
                end else if (left_only && hidx_q != '0) begin
                    hidx_d = hidx_q - CNT_W'(1);
                end else if (right_only && hidx_q < hist_last) begin
                    hidx_d = hidx_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (btn.mode) begin
                    state_d = HISTORY;
                    hidx_d  = hist_last;
                end
            end
        endcase
        blink_en_d = (state_d == EDIT) || (state_d == SUBMIT);
        over_d     = (count_d == MAX_CNT);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EDIT;
            slot_q     <= '0;
            cursor_q   <= 2'd0;
            valid_q    <= 1'b0;
            word_q     <= '0;
            count_q    <= '0;
            hidx_q     <= '0;
            blink_en_q <= 1'b1;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            cursor_q   <= cursor_d;
            valid_q    <= valid_d;
            word_q     <= word_d;
            count_q    <= count_d;
            hidx_q     <= hidx_d;
            blink_en_q <= blink_en_d;
            over_q     <= over_d;
        end
    end

    assign guess_rgb0   = slot_q[0];
    assign guess_rgb1   = slot_q[1];
    assign guess_rgb2   = slot_q[2];
    assign guess_rgb3   = slot_q[3];
    assign blink_led    = cursor_q;
    assign blink_enable = blink_en_q;
    assign guess_valid  = valid_q;
    assign guess_word   = word_q;
    assign guess_count  = count_q;
    assign history_idx  = hidx_q;
    assign game_over    = over_q;

endmodule

// File: tb/tb_guess_entry.sv
// Directed bench for guess_entry with a short debounce window.
module tb_guess_entry;

    localparam int B_LEFT = 0, B_RIGHT = 1, B_COLOR = 2, B_SUBMIT = 3, B_MODE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  btn;
    logic [2:0]  guess_rgb0, guess_rgb1, guess_rgb2, guess_rgb3;
    logic        blink_enable;
    logic [1:0]  blink_led;
    logic        guess_valid;
    logic [11:0] guess_word;
    logic [3:0]  guess_count;
    logic [3:0]  history_idx;
    logic        game_over;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int press_cyc = -100;
    int valid_cyc = -200;

    guess_entry #(.DEBOUNCE_CYCLES(4), .NUM_COLORS(6), .MAX_GUESSES(10)) dut (
        .clk(clk), .rst(rst),
        .btn_left(btn[B_LEFT]), .btn_right(btn[B_RIGHT]), .btn_color(btn[B_COLOR]),
        .btn_submit(btn[B_SUBMIT]), .btn_mode(btn[B_MODE]),
        .guess_rgb0(guess_rgb0), .guess_rgb1(guess_rgb1), .guess_rgb2(guess_rgb2), .guess_rgb3(guess_rgb3),
        .blink_enable(blink_enable), .blink_led(blink_led),
        .guess_valid(guess_valid), .guess_word(guess_word), .guess_count(guess_count),
        .history_idx(history_idx), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Pulse bookkeeping sampled on the falling edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (dut.u_db_submit.press) press_cyc <= cyc;
        if (guess_valid) begin
            valid_cnt <= valid_cnt + 1;
            valid_cyc <= cyc;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        btn = '0;
        repeat (3) @(posedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press(input int b);
        btn[b] = 1'b1;
        repeat (8) @(posedge clk);
        btn = '0;
        repeat (8) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill_and_submit();
        for (int s = 0; s < 4; s++) begin
            press(B_COLOR);
            if (s < 3) press(B_RIGHT);
        end
        press(B_SUBMIT);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({guess_rgb3, guess_rgb2, guess_rgb1, guess_rgb0} !== 12'h000) begin errors++; $display("FAIL reset_slots got=%h exp=000", {guess_rgb3, guess_rgb2, guess_rgb1, guess_rgb0}); end
        checks++; if (blink_led !== 2'd0) begin errors++; $display("FAIL reset_cursor got=%0d exp=0", blink_led); end
        checks++; if (blink_enable !== 1'b1) begin errors++; $display("FAIL reset_blink got=%b exp=1", blink_enable); end
        checks++; if (guess_valid !== 1'b0 || guess_word !== 12'h000) begin errors++; $display("FAIL reset_guess got=%b/%h exp=0/000", guess_valid, guess_word); end
        checks++; if (guess_count !== 4'd0 || history_idx !== 4'd0 || game_over !== 1'b0) begin errors++; $display("FAIL reset_counts got=%0d/%0d/%b exp=0/0/0", guess_count, history_idx, game_over); end
    endtask

    task automatic test_debounce();
        do_reset();
        btn[B_COLOR] = 1'b1;
        repeat (2) @(posedge clk);
        btn = '0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        checks++; if (guess_rgb0 !== 3'd0) begin errors++; $display("FAIL glitch_no_press got=%0d exp=0", guess_rgb0); end
        btn[B_COLOR] = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++; if (guess_rgb0 !== 3'd1) begin errors++; $display("FAIL held_press got=%0d exp=1", guess_rgb0); end
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++; if (guess_rgb0 !== 3'd1) begin errors++; $display("FAIL held_no_repeat got=%0d exp=1", guess_rgb0); end
        btn = '0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++; if (guess_rgb0 !== 3'd1) begin errors++; $display("FAIL release_no_press got=%0d exp=1", guess_rgb0); end
    endtask

    task automatic test_color_wrap();
        logic [2:0] exp;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            press(B_COLOR);
            exp = 3'((i % 6) + 1);
            checks++; if (guess_rgb0 !== exp) begin errors++; $display("FAIL color_step%0d got=%0d exp=%0d", i, guess_rgb0, exp); end
        end
        press(B_LEFT);
        checks++; if (blink_led !== 2'd3) begin errors++; $display("FAIL left_wrap got=%0d exp=3", blink_led); end
        press(B_RIGHT);
        checks++; if (blink_led !== 2'd0) begin errors++; $display("FAIL right_wrap got=%0d exp=0", blink_led); end
    endtask

    task automatic test_submit();
        int v0;
        do_reset();
        repeat (3) press(B_COLOR);
        press(B_RIGHT);
        repeat (5) press(B_COLOR);
        press(B_RIGHT);
        press(B_COLOR);
        press(B_RIGHT);
        repeat (2) press(B_COLOR);
        checks++; if ({guess_rgb3, guess_rgb2, guess_rgb1, guess_rgb0} !== 12'b010_001_101_011) begin errors++; $display("FAIL setup_slots got=%b exp=010001101011", {guess_rgb3, guess_rgb2, guess_rgb1, guess_rgb0}); end
        v0 = valid_cnt;
        press(B_SUBMIT);
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL submit_pulses got=%0d exp=1", valid_cnt - v0); end
        checks++; if (valid_cyc - press_cyc !== 1) begin errors++; $display("FAIL submit_latency got=%0d exp=1", valid_cyc - press_cyc); end
        checks++; if (guess_word !== 12'b010_001_101_011) begin errors++; $display("FAIL submit_word got=%b exp=010001101011", guess_word); end
        checks++; if (guess_count !== 4'd1) begin errors++; $display("FAIL submit_count got=%0d exp=1", guess_count); end
        checks++; if ({guess_rgb3, guess_rgb2, guess_rgb1, guess_rgb0} !== 12'h000 || blink_led !== 2'd0) begin errors++; $display("FAIL submit_clear got=%h/%0d exp=000/0", {guess_rgb3, guess_rgb2, guess_rgb1, guess_rgb0}, blink_led); end
    endtask

    task automatic test_empty_slot();
        int v0;
        do_reset();
        press(B_COLOR);
        press(B_RIGHT);
        press(B_RIGHT);
        press(B_COLOR);
        press(B_RIGHT);
        press(B_COLOR);
        v0 = valid_cnt;
        press(B_SUBMIT);
`ifdef GUESS_FULL_CHECK_EN
        checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL empty_reject got=%0d exp=0", valid_cnt - v0); end
        checks++; if (guess_count !== 4'd0 || guess_rgb0 !== 3'd1 || blink_led !== 2'd3) begin errors++; $display("FAIL empty_noop got=%0d/%0d/%0d exp=0/1/3", guess_count, guess_rgb0, blink_led); end
`else
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL empty_accept got=%0d exp=1", valid_cnt - v0); end
        checks++; if (guess_word !== 12'b001_001_000_001) begin errors++; $display("FAIL empty_word got=%b exp=001001000001", guess_word); end
`endif
    endtask

    task automatic test_history();
        do_reset();
        repeat (3) fill_and_submit();
        checks++; if (guess_count !== 4'd3) begin errors++; $display("FAIL hist_count got=%0d exp=3", guess_count); end
        repeat (2) press(B_COLOR);
        press(B_RIGHT);
        press(B_MODE);
        checks++; if (blink_enable !== 1'b0 || history_idx !== 4'd2) begin errors++; $display("FAIL hist_entry got=%b/%0d exp=0/2", blink_enable, history_idx); end
        press(B_LEFT);
        checks++; if (history_idx !== 4'd1) begin errors++; $display("FAIL hist_left got=%0d exp=1", history_idx); end
        repeat (3) press(B_LEFT);
        checks++; if (history_idx !== 4'd0) begin errors++; $display("FAIL hist_sat_low got=%0d exp=0", history_idx); end
        press(B_RIGHT);
        checks++; if (history_idx !== 4'd1) begin errors++; $display("FAIL hist_right got=%0d exp=1", history_idx); end
        repeat (3) press(B_RIGHT);
        checks++; if (history_idx !== 4'd2) begin errors++; $display("FAIL hist_sat_high got=%0d exp=2", history_idx); end
        press(B_COLOR);
        press(B_SUBMIT);
        checks++; if (guess_rgb0 !== 3'd2 || guess_count !== 4'd3) begin errors++; $display("FAIL hist_ignore got=%0d/%0d exp=2/3", guess_rgb0, guess_count); end
        press(B_MODE);
        checks++; if (blink_enable !== 1'b1 || guess_rgb0 !== 3'd2 || blink_led !== 2'd1) begin errors++; $display("FAIL hist_exit got=%b/%0d/%0d exp=1/2/1", blink_enable, guess_rgb0, blink_led); end
    endtask

    task automatic test_game_over();
        int v0;
        do_reset();
        repeat (9) fill_and_submit();
        checks++; if (game_over !== 1'b0 || guess_count !== 4'd9) begin errors++; $display("FAIL pre_over got=%b/%0d exp=0/9", game_over, guess_count); end
        fill_and_submit();
        checks++; if (game_over !== 1'b1 || guess_count !== 4'd10 || blink_enable !== 1'b0) begin errors++; $display("FAIL over got=%b/%0d/%b exp=1/10/0", game_over, guess_count, blink_enable); end
        v0 = valid_cnt;
        press(B_SUBMIT);
        press(B_COLOR);
        checks++; if (valid_cnt - v0 !== 0 || guess_count !== 4'd10 || guess_rgb0 !== 3'd0) begin errors++; $display("FAIL over_ignore got=%0d/%0d/%0d exp=0/10/0", valid_cnt - v0, guess_count, guess_rgb0); end
        press(B_MODE);
        checks++; if (history_idx !== 4'd9) begin errors++; $display("FAIL over_hist got=%0d exp=9", history_idx); end
        press(B_RIGHT);
        checks++; if (history_idx !== 4'd9) begin errors++; $display("FAIL over_hist_sat got=%0d exp=9", history_idx); end
        press(B_MODE);
        press(B_COLOR);
        checks++; if (game_over !== 1'b1 || blink_enable !== 1'b0 || guess_rgb0 !== 3'd0) begin errors++; $display("FAIL over_return got=%b/%b/%0d exp=1/0/0", game_over, blink_enable, guess_rgb0); end
    endtask

    task automatic test_reset_mid_press();
        btn[B_COLOR] = 1'b1;
        repeat (3) @(posedge clk);
        rst = 1'b1;
        btn = '0;
        repeat (2) @(posedge clk);
        rst = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        checks++; if (guess_count !== 4'd0 || game_over !== 1'b0 || blink_enable !== 1'b1 || history_idx !== 4'd0) begin errors++; $display("FAIL midrst_state got=%0d/%b/%b/%0d exp=0/0/1/0", guess_count, game_over, blink_enable, history_idx); end
        checks++; if (guess_rgb0 !== 3'd0 || guess_word !== 12'h000 || guess_valid !== 1'b0 || blink_led !== 2'd0) begin errors++; $display("FAIL midrst_outputs got=%0d/%h/%b/%0d exp=0/000/0/0", guess_rgb0, guess_word, guess_valid, blink_led); end
    endtask

    initial begin
        rst = 1'b1;
        btn = '0;
        test_reset();
        test_debounce();
        test_color_wrap();
        test_submit();
        test_empty_slot();
        test_history();
        test_game_over();
        test_reset_mid_press();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
